lsu: RTL and testbench

- Load/store unit of the multi-cycle RV32 core, sitting between EXU and WBU.
- Consumer end of the EXU valid/ready handshake: latches one EXU packet, performs at most one data-memory transaction, and presents a writeback packet to WBU through the same valid/ready handshake.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/lsu_if.sv | 53 +++++
 rtl/lsu.sv | 216 +++++++++++++++++++++
 tb/tb_lsu.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Bundle of the EXU->LSU->WBU handshakes and the data-memory bus seen by the LSU.
interface lsu_if #(
    parameter int DATA_W = 32
);
    // EXU side
    logic              i_pre_valid;
    logic              o_pre_ready;
    logic [DATA_W-1:0] i_lsu_exu_res;
    logic              i_lsu_is_load;
    logic              i_lsu_is_store;
    logic [2:0]        i_lsu_func3;
    logic [DATA_W-1:0] i_lsu_rs2;
    logic [4:0]        i_lsu_rd_id;
    logic              i_lsu_gpr_wen;
    // WBU side
    logic              o_post_valid;
    logic              i_post_ready;
    logic [DATA_W-1:0] o_lsu_wb_data;
    logic [4:0]        o_lsu_rd_id;
    logic              o_lsu_gpr_wen;
    logic              o_lsu_err;
    // data-memory bus
    logic              o_mem_req_valid;
    logic              i_mem_req_ready;
    logic              o_mem_wen;
    logic [DATA_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [3:0]        o_mem_wstrb;
    logic              i_mem_rsp_valid;
    logic              o_mem_rsp_ready;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_rsp_err;

    // LSU side of the bundle
    modport slave (
        input  i_pre_valid, i_lsu_exu_res, i_lsu_is_load, i_lsu_is_store, i_lsu_func3,
               i_lsu_rs2, i_lsu_rd_id, i_lsu_gpr_wen, i_post_ready, i_mem_req_ready,
               i_mem_rsp_valid, i_mem_rdata, i_mem_rsp_err,
        output o_pre_ready, o_post_valid, o_lsu_wb_data, o_lsu_rd_id, o_lsu_gpr_wen,
               o_lsu_err, o_mem_req_valid, o_mem_wen, o_mem_addr, o_mem_wdata,
               o_mem_wstrb, o_mem_rsp_ready
    );

    // Environment side (EXU, WBU and memory together)
    modport master (
        output i_pre_valid, i_lsu_exu_res, i_lsu_is_load, i_lsu_is_store, i_lsu_func3,
               i_lsu_rs2, i_lsu_rd_id, i_lsu_gpr_wen, i_post_ready, i_mem_req_ready,
               i_mem_rsp_valid, i_mem_rdata, i_mem_rsp_err,
        input  o_pre_ready, o_post_valid, o_lsu_wb_data, o_lsu_rd_id, o_lsu_gpr_wen,
               o_lsu_err, o_mem_req_valid, o_mem_wen, o_mem_addr, o_mem_wdata,
               o_mem_wstrb, o_mem_rsp_ready
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: takes one EXU packet, performs at most one memory access,
// and hands a writeback packet to WBU. All outputs are registered.
module lsu #(
    parameter int DATA_W = 32
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Width/alignment legality; a packet flagged as both load and store is illegal.
    function automatic logic access_ok(input logic ld, input logic st,
                                       input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        if (ld ^ st) begin
            case (f3)
                3'b000:  ok = 1'b1;
                3'b001:  ok = ~a[0];
                3'b010:  ok = (a == 2'b00);
                3'b100:  ok = ld;
                3'b101:  ok = ld & ~a[0];
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Replicate store data across lanes and build the byte strobes: {wdata, wstrb}.
    function automatic logic [DATA_W+3:0] store_lanes(input logic [DATA_W-1:0] rs2,
                                                      input logic [2:0] f3,
                                                      input logic [1:0] a);
        logic [DATA_W+3:0] r;
        case (f3[1:0])
            2'b00:   r = {{4{rs2[7:0]}}, 4'b0001 << a};
            2'b01:   r = {{2{rs2[15:0]}}, 4'b0011 << a};
            default: r = {rs2, 4'b1111};
        endcase
        return r;
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] w,
                                                       input logic [2:0] f3,
                                                       input logic [1:0] a);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'b0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'b0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        off_q, off_d;
    logic              is_load_q, is_load_d;
    logic              pkt_wen_q, pkt_wen_d;
    logic              req_valid_q, req_valid_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              rsp_ready_q, rsp_ready_d;
    logic              post_valid_q, post_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        rd_id_q, rd_id_d;
    logic              gpr_wen_q, gpr_wen_d;
    logic              err_q, err_d;

    logic pkt_is_mem;
    logic pkt_ok;
    assign pkt_is_mem = bus.i_lsu_is_load | bus.i_lsu_is_store;
    assign pkt_ok     = access_ok(bus.i_lsu_is_load, bus.i_lsu_is_store,
                                  bus.i_lsu_func3, bus.i_lsu_exu_res[1:0]);

    // Next-state and next-output logic for the IDLE/REQ/RESP/DONE sequence.
    always_comb begin
        state_d      = state_q;
        func3_d      = func3_q;
        off_d        = off_q;
        is_load_d    = is_load_q;
        pkt_wen_d    = pkt_wen_q;
        req_valid_d  = req_valid_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rsp_ready_d  = rsp_ready_q;
        post_valid_d = post_valid_q;
        wb_data_d    = wb_data_q;
        rd_id_d      = rd_id_q;
        gpr_wen_d    = gpr_wen_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (bus.i_pre_valid) begin
                    func3_d   = bus.i_lsu_func3;
                    off_d     = bus.i_lsu_exu_res[1:0];
                    is_load_d = bus.i_lsu_is_load;
                    pkt_wen_d = bus.i_lsu_gpr_wen;
                    rd_id_d   = bus.i_lsu_rd_id;
                    if (pkt_is_mem && pkt_ok) begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        wen_d       = bus.i_lsu_is_store;
                        addr_d      = {bus.i_lsu_exu_res[DATA_W-1:2], 2'b00};
                        {wdata_d, wstrb_d} = bus.i_lsu_is_store
                            ? store_lanes(bus.i_lsu_rs2, bus.i_lsu_func3, bus.i_lsu_exu_res[1:0])
                            : '0;
                        err_d       = 1'b0;
                    end else begin
                        // Non-memory pass-through, or a faulting access with no bus traffic.
                        state_d      = DONE;
                        post_valid_d = 1'b1;
                        err_d        = pkt_is_mem;
                        wb_data_d    = pkt_is_mem ? '0 : bus.i_lsu_exu_res;
                        gpr_wen_d    = pkt_is_mem ? 1'b0 : bus.i_lsu_gpr_wen;
                    end
                end
            end
            REQ: begin
                if (bus.i_mem_req_ready) begin
                    state_d     = RESP;
                    req_valid_d = 1'b0;
                    rsp_ready_d = 1'b1;
                end
            end
            RESP: begin
                if (bus.i_mem_rsp_valid) begin
                    state_d      = DONE;
                    rsp_ready_d  = 1'b0;
                    post_valid_d = 1'b1;
                    err_d        = bus.i_mem_rsp_err;
                    wb_data_d    = (bus.i_mem_rsp_err || !is_load_q)
                                   ? '0 : load_extract(bus.i_mem_rdata, func3_q, off_q);
                    gpr_wen_d    = !bus.i_mem_rsp_err && is_load_q && pkt_wen_q;
                end
            end
            default: begin
                if (bus.i_post_ready) begin
                    state_d      = IDLE;
                    post_valid_d = 1'b0;
                end
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            func3_q      <= '0;
            off_q        <= '0;
            is_load_q    <= 1'b0;
            pkt_wen_q    <= 1'b0;
            req_valid_q  <= 1'b0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rsp_ready_q  <= 1'b0;
            post_valid_q <= 1'b0;
            wb_data_q    <= '0;
            rd_id_q      <= '0;
            gpr_wen_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            func3_q      <= func3_d;
            off_q        <= off_d;
            is_load_q    <= is_load_d;
            pkt_wen_q    <= pkt_wen_d;
            req_valid_q  <= req_valid_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rsp_ready_q  <= rsp_ready_d;
            post_valid_q <= post_valid_d;
            wb_data_q    <= wb_data_d;
            rd_id_q      <= rd_id_d;
            gpr_wen_q    <= gpr_wen_d;
            err_q        <= err_d;
        end
    end

    assign bus.o_pre_ready     = (state_q == IDLE);
    assign bus.o_mem_req_valid = req_valid_q;
    assign bus.o_mem_wen       = wen_q;
    assign bus.o_mem_addr      = addr_q;
    assign bus.o_mem_wdata     = wdata_q;
    assign bus.o_mem_wstrb     = wstrb_q;
    assign bus.o_mem_rsp_ready = rsp_ready_q;
    assign bus.o_post_valid    = post_valid_q;
    assign bus.o_lsu_wb_data   = wb_data_q;
    assign bus.o_lsu_rd_id     = rd_id_q;
    assign bus.o_lsu_gpr_wen   = gpr_wen_q;
    assign bus.o_lsu_err       = err_q;
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases followed by randomized packets, compared against
// a byte-addressed memory model and the access rules written out arithmetically.
module tb_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] bus_mem [16];   // memory as seen over the bus (word array)
    logic [7:0]  ref_mem [64];   // reference copy (byte array), aliased on addr[5:0]

    lsu_if #(.DATA_W(32)) bus ();

    lsu #(.DATA_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int idx, input logic [31:0] w);
        bus_mem[idx] = w;
        for (int k = 0; k < 4; k++) ref_mem[idx*4 + k] = w[8*k +: 8];
    endtask

    function automatic bit is_fault(input bit ld, input bit st, input logic [2:0] f3,
                                    input logic [31:0] a);
        int sz;
        if (!ld && !st) return 1'b0;
        if (ld && st) return 1'b1;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (st && f3 > 3'd2) return 1'b1;
        sz = 1 << f3[1:0];
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        int sz;
        logic [31:0] v, mask;
        sz = 1 << f3[1:0];
        v  = 32'h0;
        for (int k = 0; k < sz; k++)
            v = v | (32'(ref_mem[(int'(a[5:0]) + k) % 64]) << (8*k));
        mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8*sz)) - 64'd1);
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input int sz);
        for (int k = 0; k < sz; k++) ref_mem[(int'(a[5:0]) + k) % 64] = d[8*k +: 8];
    endtask

    task automatic scramble_pkt();
        bus.i_lsu_exu_res  = $urandom;
        bus.i_lsu_is_load  = 1'($urandom_range(0, 1));
        bus.i_lsu_is_store = 1'($urandom_range(0, 1));
        bus.i_lsu_func3    = 3'($urandom_range(0, 7));
        bus.i_lsu_rs2      = $urandom;
        bus.i_lsu_rd_id    = 5'($urandom_range(0, 31));
        bus.i_lsu_gpr_wen  = 1'($urandom_range(0, 1));
    endtask

    task automatic txn(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] res, input logic [31:0] rs2, input logic [4:0] rd,
                       input bit gw, input bit berr,
                       input int req_wait, input int rsp_wait, input int post_wait);
        bit          fault, use_bus, e_gw, e_err;
        int          sz;
        logic [1:0]  off;
        logic [31:0] e_addr, e_wdata, e_wb, s_addr, s_wdata, rword;
        logic [3:0]  e_wstrb, s_wstrb;
        logic        s_wen;

        fault   = is_fault(ld, st, f3, res);
        use_bus = (ld || st) && !fault;
        sz      = 1 << f3[1:0];
        off     = res[1:0];
        e_addr  = {res[31:2], 2'b00};
        e_wstrb = 4'h0;
        e_wdata = 32'h0;
        if (st && use_bus) begin
            e_wstrb = 4'(((1 << sz) - 1) << off);
            for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = rs2[8*(i % sz) +: 8];
        end
        if (!ld && !st) begin
            e_wb = res;  e_gw = gw;   e_err = 1'b0;
        end else if (fault || berr) begin
            e_wb = 32'h0; e_gw = 1'b0; e_err = 1'b1;
        end else if (st) begin
            e_wb = 32'h0; e_gw = 1'b0; e_err = 1'b0;
        end else begin
            e_wb = ref_load(res, f3); e_gw = gw; e_err = 1'b0;
        end
        if (st && use_bus && !berr) ref_store(res, rs2, sz);

        chk("pre_ready_idle", 32'(bus.o_pre_ready), 1);
        bus.i_pre_valid    = 1'b1;
        bus.i_lsu_is_load  = ld;
        bus.i_lsu_is_store = st;
        bus.i_lsu_func3    = f3;
        bus.i_lsu_exu_res  = res;
        bus.i_lsu_rs2      = rs2;
        bus.i_lsu_rd_id    = rd;
        bus.i_lsu_gpr_wen  = gw;
        step();
        bus.i_pre_valid = 1'b0;
        scramble_pkt();

        if (use_bus) begin
            for (int c = 0; c <= req_wait; c++) begin
                if (c > 0) step();
                chk("req_valid", 32'(bus.o_mem_req_valid), 1);
                chk("req_addr", bus.o_mem_addr, e_addr);
                chk("req_wen", 32'(bus.o_mem_wen), 32'(st));
                chk("req_wstrb", 32'(bus.o_mem_wstrb), 32'(e_wstrb));
                if (st) chk("req_wdata", bus.o_mem_wdata, e_wdata);
                chk("req_pre_ready", 32'(bus.o_pre_ready), 0);
                chk("req_rsp_ready", 32'(bus.o_mem_rsp_ready), 0);
            end
            s_addr  = bus.o_mem_addr;
            s_wdata = bus.o_mem_wdata;
            s_wstrb = bus.o_mem_wstrb;
            s_wen   = bus.o_mem_wen;
            bus.i_mem_req_ready = 1'b1;
            step();
            bus.i_mem_req_ready = 1'b0;
            chk("resp_req_valid", 32'(bus.o_mem_req_valid), 0);
            if (s_wen && !berr)
                for (int i = 0; i < 4; i++)
                    if (s_wstrb[i]) bus_mem[s_addr[5:2]][8*i +: 8] = s_wdata[8*i +: 8];
            rword = bus_mem[s_addr[5:2]];
            for (int c = 0; c <= rsp_wait; c++) begin
                if (c > 0) step();
                chk("resp_rsp_ready", 32'(bus.o_mem_rsp_ready), 1);
                chk("resp_post_valid", 32'(bus.o_post_valid), 0);
            end
            bus.i_mem_rsp_valid = 1'b1;
            bus.i_mem_rdata     = s_wen ? $urandom : rword;
            bus.i_mem_rsp_err   = berr;
            step();
            bus.i_mem_rsp_valid = 1'b0;
            bus.i_mem_rsp_err   = 1'b0;
            bus.i_mem_rdata     = $urandom;
        end

        for (int c = 0; c <= post_wait; c++) begin
            chk("done_post_valid", 32'(bus.o_post_valid), 1);
            chk("done_wb_data", bus.o_lsu_wb_data, e_wb);
            chk("done_rd_id", 32'(bus.o_lsu_rd_id), 32'(rd));
            chk("done_gpr_wen", 32'(bus.o_lsu_gpr_wen), 32'(e_gw));
            chk("done_err", 32'(bus.o_lsu_err), 32'(e_err));
            chk("done_pre_ready", 32'(bus.o_pre_ready), 0);
            chk("done_req_valid", 32'(bus.o_mem_req_valid), 0);
            chk("done_rsp_ready", 32'(bus.o_mem_rsp_ready), 0);
            if (c < post_wait) begin
                bus.i_pre_valid = 1'($urandom_range(0, 1));
                scramble_pkt();
                step();
            end
        end
        bus.i_pre_valid  = 1'b0;
        bus.i_post_ready = 1'b1;
        step();
        bus.i_post_ready = 1'b0;
        chk("hs_post_valid", 32'(bus.o_post_valid), 0);
        chk("hs_pre_ready", 32'(bus.o_pre_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ld, st, gw, berr;
        logic [2:0]  f3;
        logic [31:0] res;
        int          r;

        bus.i_pre_valid     = 1'b0;
        bus.i_post_ready    = 1'b0;
        bus.i_mem_req_ready = 1'b0;
        bus.i_mem_rsp_valid = 1'b0;
        bus.i_mem_rsp_err   = 1'b0;
        bus.i_mem_rdata     = 32'h0;
        scramble_pkt();
        for (int i = 0; i < 16; i++) set_word(i, $urandom);

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_pre_ready", 32'(bus.o_pre_ready), 1);
        chk("rst_post_valid", 32'(bus.o_post_valid), 0);
        chk("rst_req_valid", 32'(bus.o_mem_req_valid), 0);
        chk("rst_rsp_ready", 32'(bus.o_mem_rsp_ready), 0);
        chk("rst_wb_data", bus.o_lsu_wb_data, 0);
        chk("rst_err", 32'(bus.o_lsu_err), 0);

        // Directed cases
        txn(0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 0, 0, 0);
        set_word(0, 32'h8077_66F0);
        txn(1, 0, 3'b000, 32'h8000_0003, 32'h0, 5'd7, 1, 0, 0, 0, 0);
        txn(1, 0, 3'b100, 32'h8000_0003, 32'h0, 5'd8, 1, 0, 0, 1, 0);
        txn(0, 1, 3'b001, 32'h8000_0102, 32'hDEAD_BEEF, 5'd9, 1, 0, 0, 0, 0);
        txn(1, 0, 3'b010, 32'h8000_0100, 32'h0, 5'd10, 1, 0, 4, 0, 3);
        txn(1, 0, 3'b010, 32'h8000_0002, 32'h0, 5'd11, 1, 0, 0, 0, 0);
        txn(1, 0, 3'b010, 32'h8000_0004, 32'h0, 5'd12, 1, 1, 0, 2, 0);
        txn(1, 1, 3'b000, 32'h8000_0000, 32'h0, 5'd13, 1, 0, 0, 0, 0);

        // Reset while waiting for the response
        bus.i_pre_valid    = 1'b1;
        bus.i_lsu_is_load  = 1'b1;
        bus.i_lsu_is_store = 1'b0;
        bus.i_lsu_func3    = 3'b010;
        bus.i_lsu_exu_res  = 32'h8000_0008;
        bus.i_lsu_rd_id    = 5'd21;
        bus.i_lsu_gpr_wen  = 1'b1;
        step();
        bus.i_pre_valid     = 1'b0;
        bus.i_mem_req_ready = 1'b1;
        step();
        bus.i_mem_req_ready = 1'b0;
        chk("mid_rsp_ready", 32'(bus.o_mem_rsp_ready), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_pre_ready", 32'(bus.o_pre_ready), 1);
        chk("mid_rst_rsp_ready", 32'(bus.o_mem_rsp_ready), 0);
        chk("mid_rst_req_valid", 32'(bus.o_mem_req_valid), 0);
        chk("mid_rst_post_valid", 32'(bus.o_post_valid), 0);
        chk("mid_rst_addr", bus.o_mem_addr, 0);
        chk("mid_rst_rd_id", 32'(bus.o_lsu_rd_id), 0);
        chk("mid_rst_gpr_wen", 32'(bus.o_lsu_gpr_wen), 0);

        // Randomized packets
        for (int n = 0; n < 250; n++) begin
            r    = $urandom_range(0, 9);
            ld   = (r >= 3 && r <= 5) || r == 9;
            st   = (r >= 6);
            gw   = 1'($urandom_range(0, 1));
            berr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) != 0)
                f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2) + ($urandom_range(0, 1) ? 0 : 4) * 1);
            else
                f3 = 3'($urandom_range(0, 7));
            if (!ld && !st) begin
                res = $urandom;
            end else begin
                res = 32'h8000_0000 | 32'($urandom_range(0, 63));
                if ($urandom_range(0, 2) != 0) res = res & ~32'((1 << f3[1:0]) - 1);
            end
            txn(ld, st, f3, res, $urandom, 5'($urandom_range(0, 31)), gw, berr,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
